// File: rtl/tpu_pkg.sv
// Shared types, default widths and the accumulator saturation helper for the
// tpu_mac_array multiply-accumulate engine.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SUM  = 2'd2,
    ACC  = 2'd3
  } state_t;

  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ACC_W  = 32;
  localparam int unsigned DEF_OUT_W  = 16;

  // Widest accumulator the saturation helper supports (ACC_W must be below this).
  localparam int unsigned MAX_ACC_W  = 64;

  typedef struct packed {
    logic                 ovf;
    logic [MAX_ACC_W-1:0] value;
  } sat_t;

  // val carries an (acc_w+1)-bit result, zero- or sign-extended to MAX_ACC_W+1
  // bits. Bit acc_w is the carry (unsigned) or the true sign (signed).
  function automatic sat_t saturate(input logic [MAX_ACC_W:0] val,
                                    input int unsigned       acc_w,
                                    input logic              is_signed);
    logic [MAX_ACC_W-1:0] mask;
    logic [6:0]           idx;
    sat_t                 r;
    idx     = acc_w[6:0];
    mask    = '1;
    mask    = mask >> (MAX_ACC_W - acc_w);
    r.ovf   = 1'b0;
    r.value = val[MAX_ACC_W-1:0] & mask;
    if (!is_signed) begin
      if (val[idx]) begin
        r.ovf   = 1'b1;
        r.value = mask;
      end
    end else if (val[idx] != val[idx - 7'd1]) begin
      r.ovf   = 1'b1;
      r.value = val[idx] ? (mask & ~(mask >> 1)) : (mask >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/tpu_mac_array_if.sv
// Operand/result bus between the operand loader, the MAC array and readout.
interface tpu_mac_array_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 16
);
  logic                    sync;
  logic                    clear;
  logic                    out_HL;
  logic                    err_clr;
  logic [LANES*DATA_W-1:0] input1;
  logic [LANES*DATA_W-1:0] input2;
  logic                    ready;
  logic                    valid;
  logic                    error;
  logic [OUT_W-1:0]        out;

  modport master (
    output sync, clear, out_HL, err_clr, input1, input2,
    input  ready, valid, error, out
  );

  modport slave (
    input  sync, clear, out_HL, err_clr, input1, input2,
    output ready, valid, error, out
  );
endinterface

// File: rtl/tpu_lane_mul.sv
// Single multiplier lane: registers a full-width product of two operands.
module tpu_lane_mul #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   product
);

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;

  // Extend operands to product width so the low 2*DATA_W bits of the
  // multiplication are exact for either signedness.
  always_comb begin
    a_ext = {{DATA_W{1'b0}}, a};
    b_ext = {{DATA_W{1'b0}}, b};
    if (SIGNED != 0) begin
      a_ext = {{DATA_W{a[DATA_W-1]}}, a};
      b_ext = {{DATA_W{b[DATA_W-1]}}, b};
    end
  end

  // Product register, loaded only during the multiply step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
    end else if (en) begin
      product <= a_ext * b_ext;
    end
  end

endmodule

// File: rtl/tpu_mac_array.sv
// LANES-wide dot-product multiply-accumulate engine with a saturating
// accumulator and half-select output bus.
module tpu_mac_array
  import tpu_pkg::*;
#(
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned SIGNED = 0
) (
  input logic             clk,
  input logic             reset,
  tpu_mac_array_if.slave  bus
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  state_t                  state;
  state_t                  state_next;
  logic [LANES*DATA_W-1:0] opa;
  logic [LANES*DATA_W-1:0] opb;
  logic                    clear_q;
  logic [PROD_W-1:0]       prod [LANES];
  logic [ACC_W:0]          tree;
  logic [ACC_W:0]          sum_q;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W:0]          acc_ext;
  logic [ACC_W:0]          total;
  logic [MAX_ACC_W:0]      sat_in;
  sat_t                    sat_r;
  logic                    valid_q;
  logic                    error_q;
  logic                    err_set;
  logic                    unused_sat;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    tpu_lane_mul #(
      .DATA_W (DATA_W),
      .SIGNED (SIGNED)
    ) u_mul (
      .clk     (clk),
      .rst_n   (reset),
      .en      (state == MUL),
      .a       (opa[g*DATA_W +: DATA_W]),
      .b       (opb[g*DATA_W +: DATA_W]),
      .product (prod[g])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fixed four-step sequence; only IDLE waits for a start pulse.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.sync) state_next = MUL;
      MUL:     state_next = SUM;
      SUM:     state_next = ACC;
      ACC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture operands and the clear request when a start is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opa     <= '0;
      opb     <= '0;
      clear_q <= 1'b0;
    end else if (state == IDLE && bus.sync) begin
      opa     <= bus.input1;
      opb     <= bus.input2;
      clear_q <= bus.clear;
    end
  end

  // Adder tree over the lane products, each extended to ACC_W+1 bits.
  always_comb begin
    tree = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (SIGNED != 0) begin
        tree = tree + {{(ACC_W+1-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
      end else begin
        tree = tree + {{(ACC_W+1-PROD_W){1'b0}}, prod[i]};
      end
    end
  end

  // Accumulate or restart, then clamp to the ACC_W range.
  always_comb begin
    acc_ext = (SIGNED != 0) ? {acc[ACC_W-1], acc} : {1'b0, acc};
    total   = clear_q ? sum_q : acc_ext + sum_q;
    if (SIGNED != 0) begin
      sat_in = {{(MAX_ACC_W-ACC_W){total[ACC_W]}}, total};
    end else begin
      sat_in = {{(MAX_ACC_W-ACC_W){1'b0}}, total};
    end
    sat_r = saturate(sat_in, ACC_W, SIGNED != 0);
  end

  assign unused_sat = ^sat_r.value[MAX_ACC_W-1:ACC_W];

  // Sum register, accumulator and the one-cycle completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q   <= '0;
      acc     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE:    if (!bus.sync && bus.clear) acc <= '0;
        SUM:     sum_q <= tree;
        ACC: begin
          acc     <= sat_r.value[ACC_W-1:0];
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign err_set = (bus.sync && state != IDLE) || (state == ACC && sat_r.ovf);

  // Sticky error; a new event takes priority over a clear request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else if (err_set) begin
      error_q <= 1'b1;
    end else if (bus.err_clr) begin
      error_q <= 1'b0;
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.valid = valid_q;
  assign bus.error = error_q;
  assign bus.out   = bus.out_HL ? acc[ACC_W-1:OUT_W] : acc[OUT_W-1:0];

endmodule

// File: tb/tb_tpu_mac_array.sv
// Scoreboard bench for tpu_mac_array: three configurations (unsigned 32-bit,
// unsigned 18-bit, signed 32-bit) share one clock and reset.
module tb_tpu_mac_array;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tpu_mac_array_if #(.LANES(4), .DATA_W(8), .OUT_W(16)) b0 ();
  tpu_mac_array_if #(.LANES(4), .DATA_W(8), .OUT_W(9))  b1 ();
  tpu_mac_array_if #(.LANES(4), .DATA_W(8), .OUT_W(16)) b2 ();

  tpu_mac_array #(.LANES(4), .DATA_W(8), .ACC_W(32), .OUT_W(16), .SIGNED(0))
    u0 (.clk(clk), .reset(reset), .bus(b0));
  tpu_mac_array #(.LANES(4), .DATA_W(8), .ACC_W(18), .OUT_W(9), .SIGNED(0))
    u1 (.clk(clk), .reset(reset), .bus(b1));
  tpu_mac_array #(.LANES(4), .DATA_W(8), .ACC_W(32), .OUT_W(16), .SIGNED(1))
    u2 (.clk(clk), .reset(reset), .bus(b2));

  typedef struct {
    logic [31:0] acc;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t e0, e1, e2;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic no_exp(input string name);
    total++;
    bad++;
    $display("FAIL %s: valid pulse with no outstanding operation", name);
  endtask

  // Monitors: compare the presented half of the accumulator and the error flag.
  always @(negedge clk) begin
    if (b0.valid === 1'b1) begin
      if (q0.size() == 0) no_exp("dut0 valid");
      else begin
        e0 = q0.pop_front();
        check("dut0 out", {16'b0, b0.out}, b0.out_HL ? {16'b0, e0.acc[31:16]} : {16'b0, e0.acc[15:0]});
        check("dut0 error", {31'b0, b0.error}, {31'b0, e0.err});
      end
    end
  end

  always @(negedge clk) begin
    if (b1.valid === 1'b1) begin
      if (q1.size() == 0) no_exp("dut1 valid");
      else begin
        e1 = q1.pop_front();
        check("dut1 out", {23'b0, b1.out}, b1.out_HL ? {23'b0, e1.acc[17:9]} : {23'b0, e1.acc[8:0]});
        check("dut1 error", {31'b0, b1.error}, {31'b0, e1.err});
      end
    end
  end

  always @(negedge clk) begin
    if (b2.valid === 1'b1) begin
      if (q2.size() == 0) no_exp("dut2 valid");
      else begin
        e2 = q2.pop_front();
        check("dut2 out", {16'b0, b2.out}, b2.out_HL ? {16'b0, e2.acc[31:16]} : {16'b0, e2.acc[15:0]});
        check("dut2 error", {31'b0, b2.error}, {31'b0, e2.err});
      end
    end
  end

  task automatic drive(input int d, input logic s, input logic c, input logic ec,
                       input logic [31:0] a, input logic [31:0] bb);
    case (d)
      0: begin b0.sync = s; b0.clear = c; b0.err_clr = ec; b0.input1 = a; b0.input2 = bb; end
      1: begin b1.sync = s; b1.clear = c; b1.err_clr = ec; b1.input1 = a; b1.input2 = bb; end
      default: begin b2.sync = s; b2.clear = c; b2.err_clr = ec; b2.input1 = a; b2.input2 = bb; end
    endcase
  endtask

  task automatic set_hl(input int d, input logic v);
    case (d)
      0: b0.out_HL = v;
      1: b1.out_HL = v;
      default: b2.out_HL = v;
    endcase
  endtask

  function automatic logic rdy(input int d);
    case (d)
      0: return b0.ready;
      1: return b1.ready;
      default: return b2.ready;
    endcase
  endfunction

  function automatic logic vld(input int d);
    case (d)
      0: return b0.valid;
      1: return b1.valid;
      default: return b2.valid;
    endcase
  endfunction

  function automatic logic errf(input int d);
    case (d)
      0: return b0.error;
      1: return b1.error;
      default: return b2.error;
    endcase
  endfunction

  function automatic logic [31:0] outv(input int d);
    case (d)
      0: return {16'b0, b0.out};
      1: return {23'b0, b1.out};
      default: return {16'b0, b2.out};
    endcase
  endfunction

  task automatic push(input int d, input logic [31:0] acc, input logic err);
    exp_t e;
    e.acc = acc;
    e.err = err;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // One operation; bump re-asserts sync (with clear and err_clr) in the
  // cycle after acceptance. Returns #1 after the edge that raises valid.
  task automatic op(input int d, input logic [31:0] a, input logic [31:0] bb,
                    input logic clr, input logic bump,
                    input logic [31:0] exp_acc, input logic exp_err);
    int n;
    int low;
    push(d, exp_acc, exp_err);
    n = 0;
    while (rdy(d) !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) begin
      total++;
      bad++;
      $display("FAIL dut%0d ready_wait: ready still low after 20 cycles", d);
    end
    drive(d, 1'b1, clr, 1'b0, a, bb);
    @(posedge clk); #1;
    if (bump) drive(d, 1'b1, 1'b1, 1'b1, '1, '1);
    else      drive(d, 1'b0, 1'b0, 1'b0, '0, '0);
    low = 0;
    while (rdy(d) !== 1'b1 && low < 10) begin
      low++;
      @(posedge clk); #1;
      drive(d, 1'b0, 1'b0, 1'b0, '0, '0);
    end
    check($sformatf("dut%0d ready_low_cycles", d), 32'(low), 32'd3);
    check($sformatf("dut%0d valid_rise", d), {31'b0, vld(d)}, 32'd1);
  endtask

  task automatic err_pulse(input int d);
    drive(d, 1'b0, 1'b0, 1'b1, '0, '0);
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, 1'b0, '0, '0);
    check($sformatf("dut%0d err_clr", d), {31'b0, errf(d)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      drive(d, 1'b0, 1'b0, 1'b0, '0, '0);
      set_hl(d, 1'b0);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst ready", {31'b0, rdy(0)}, 32'd1);
    check("rst valid", {31'b0, vld(0)}, 32'd0);
    check("rst error", {31'b0, errf(0)}, 32'd0);
    check("rst out", outv(0), 32'd0);
    check("rst out dut1", outv(1), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Unsigned dot product with clear: 5+12+21+32 = 70.
    op(0, 32'h04030201, 32'h08070605, 1'b1, 1'b0, 32'h0000_0046, 1'b0);
    set_hl(0, 1'b1); #1;
    check("s1 out_hi", outv(0), 32'h0000);
    check("s1 error", {31'b0, errf(0)}, 32'd0);
    @(posedge clk); #1;
    check("s1 valid_fall", {31'b0, vld(0)}, 32'd0);

    // Accumulate 4*255*255 onto 70.
    op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0003_F84A, 1'b0);
    set_hl(0, 1'b0); #1;
    check("s2 out_lo", outv(0), 32'hF84A);

    // Idle clear without sync zeroes the accumulator.
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 1'b0, '0, '0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    check("idle_clear lo", outv(0), 32'd0);
    set_hl(0, 1'b1); #1;
    check("idle_clear hi", outv(0), 32'd0);
    set_hl(0, 1'b0);

    // Sync, clear and err_clr while busy: op unaffected, error set wins.
    op(0, 32'h04030201, 32'h08070605, 1'b1, 1'b1, 32'h0000_0046, 1'b1);
    check("busy_sync error", {31'b0, errf(0)}, 32'd1);
    err_pulse(0);

    // 18-bit accumulator: 70 + 260100 = 0x3F84A, then saturates at 0x3FFFF.
    op(1, 32'h04030201, 32'h08070605, 1'b1, 1'b0, 32'h0000_0046, 1'b0);
    op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0003_F84A, 1'b0);
    set_hl(1, 1'b1);
    op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0003_FFFF, 1'b1);
    set_hl(1, 1'b0); #1;
    check("sat out_lo", outv(1), 32'h1FF);
    check("sat error", {31'b0, errf(1)}, 32'd1);
    @(posedge clk); #1;
    err_pulse(1);

    // Signed: -5+10-15+20 = 10, then 10 + 4*(-128*127) = -65014.
    op(2, 32'h04FD02FF, 32'h05050505, 1'b1, 1'b0, 32'h0000_000A, 1'b0);
    set_hl(2, 1'b1);
    op(2, 32'h80808080, 32'h7F7F7F7F, 1'b0, 1'b0, 32'hFFFF_020A, 1'b0);
    set_hl(2, 1'b0); #1;
    check("signed out_lo", outv(2), 32'h020A);
    check("signed error", {31'b0, errf(2)}, 32'd0);

    // Reset during SUM abandons the operation.
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst ready", {31'b0, rdy(0)}, 32'd1);
    check("midrst out", outv(0), 32'd0);
    check("midrst error", {31'b0, errf(0)}, 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    op(0, 32'h04030201, 32'h08070605, 1'b0, 1'b0, 32'h0000_0046, 1'b0);
    @(posedge clk); #1;

    total++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      bad++;
      $display("FAIL pending: %0d expected results never presented, required 0",
               q0.size() + q1.size() + q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
